riscv_perf_counters: RTL and testbench
======================================

// Module: riscv_perf_counters
// PURPOSE
//  Parametrised performance-counter unit for the RI5CY core; next generation of the fixed 11-counter PCCR/PCER/PCMR logic.
//  Provides N_CNT counters of CNT_WIDTH bits. Each counter has its own event selector over N_EVENTS inputs.
//  Adds wrap/saturate mode, sticky overflow status and an optional overflow interrupt.
//  Sits beside the CSR file and answers CSR accesses in the 0x780-0x7AF window.
// PARAMETERS
//  N_CNT        4   number of counters, 1..8
//  CNT_WIDTH    32  counter width, 1..64; bits above 31 are read through the high-half addresses
//  N_EVENTS     16  number of event inputs, 2..32
//  EVT_SEL_BITS $clog2(N_EVENTS)  width of each event-select field
// PORTS
//  clk           in   1         core clock
//  rst           in   1         synchronous, active-high reset
//  csr_access_i  in   1         CSR access valid this cycle
//  csr_addr_i    in   12        CSR address
//  csr_wdata_i   in   32        CSR write operand
//  csr_op_i      in   2         CSR_OP_NONE/WRITE/SET/CLEAR
//  csr_rdata_o   out  32        read data; combinational
//  csr_hit_o     out  1         address decodes to this block
//  events_i      in   N_EVENTS  single-cycle event strobes
//  perf_irq_o    out  1         overflow interrupt, level-sensitive
// BEHAVIOUR
//  Address map (only decoded when csr_access_i=1; otherwise hit=0 and rdata=0):
//   0x780+i  CNT_LO[i], bits [31:0] of counter i
//   0x790+i  CNT_HI[i], bits [CNT_WIDTH-1:32]; reads 0 and ignores writes if CNT_WIDTH<=32
//   0x7A0    EN: bit i enables counter i
//   0x7A1    MODE: bit0 global enable, bit1 saturate (1) / wrap (0)
//   0x7A2    OVF: sticky overflow bit per counter
//   0x7A3    OVF_IE: overflow interrupt enable; present only with the macro
//   0x7A8+i  EVSEL[i], EVT_SEL_BITS wide
//   Indices i>=N_CNT and unlisted addresses: hit=0, rdata=0, no state change.
//  CSR ops: WRITE r=wd; SET r=r|wd; CLEAR r=r&~wd. All apply at the clk edge after the access cycle. NONE = pure read.
//   Unimplemented register bits read 0.
//  Reset: all counters=0, EN=0, MODE=2'b11, OVF=0, OVF_IE=0, EVSEL=0, event pipeline=0. Outputs: perf_irq_o=0, csr_hit_o=0, csr_rdata_o=0.
//  Increment pipeline: inc_q[i] <= EN[i] & MODE[0] & events_i[EVSEL[i]]; the counter adds 1 when inc_q[i]=1.
//   An event strobe in cycle t becomes readable from cycle t+2. Counting rate is at most +1 per counter per cycle.
//  Boundary at all-ones with inc_q=1:
//   wrap mode: counter goes to 0 and OVF[i] is set.
//   saturate mode: counter holds all-ones and OVF[i] is set.
//  A CSR write to a counter (LO or HI) in the same cycle as an increment: the write wins and that increment is lost.
//  A CSR clear of OVF[i] in the same cycle as a new overflow of counter i: the set wins.
//  Changing EVSEL[i] or EN[i] affects inc_q from the following cycle; an increment already in inc_q still lands.
//  EVSEL values >= N_EVENTS select constant 0, so that counter never counts.
//  Synchronous reset during operation clears every register at that edge, including pending inc_q.
// CONFIGURATION
//  PERF_OVF_IRQ_EN defined:
//   OVF_IE register exists at 0x7A3 (N_CNT bits).
//   perf_irq_o = |(OVF & OVF_IE), registered; it asserts 1 cycle after the OVF bit sets.
//  PERF_OVF_IRQ_EN undefined:
//   0x7A3 behaves as unmapped (hit=0, rdata=0).
//   perf_irq_o is tied to 0; OVF is still maintained and readable.
// TESTING
//  Reset, then read 0x7A1 -> 0x3; read 0x780 -> 0; read 0x7A3 -> 0; perf_irq_o=0.
//  EVSEL[1]=5, EN=0x2, pulse events_i[5] for 10 cycles -> CNT_LO[1]=10; counter 0 stays 0.
//  MODE=0b01 (wrap), CNT_LO[0]=0xFFFFFFFF (CNT_WIDTH=32), one event -> CNT_LO[0]=0 and OVF=0x1.
//   Repeat with MODE=0b11 -> CNT_LO[0] stays 0xFFFFFFFF and OVF=0x1.
//  Counter incrementing every cycle plus CSR WRITE 0x100 to that counter -> reads 0x100 next cycle, then 0x101.
//  With the macro: OVF_IE=0x1, force an overflow on counter 0 -> perf_irq_o=1; CLEAR OVF bit0 -> perf_irq_o=0 one cycle later.
//  CNT_WIDTH=40: CNT_HI=0, CNT_LO=0xFFFFFFFF, one event -> CNT_HI=1, CNT_LO=0, OVF=0.

Source files
------------

// File: rtl/riscv_perf_counters_if.sv
// CSR access channel between the core CSR file and the performance-counter unit.
// Latency: request fields are sampled by the slave on the clock edge; rdata/hit return combinationally.
// Backpressure: none; every access completes in the cycle it is presented.
//
// Signals:
//   csr_access_i  access valid this cycle
//   csr_addr_i    12-bit CSR address
//   csr_wdata_i   32-bit write operand
//   csr_op_i      NONE / WRITE / SET / CLEAR
//   csr_rdata_o   read data (combinational from the slave)
//   csr_hit_o     address decodes to the slave
interface riscv_perf_counters_if;
  logic        csr_access_i;
  logic [11:0] csr_addr_i;
  logic [31:0] csr_wdata_i;
  logic [1:0]  csr_op_i;
  logic [31:0] csr_rdata_o;
  logic        csr_hit_o;

  modport master (
    output csr_access_i, csr_addr_i, csr_wdata_i, csr_op_i,
    input  csr_rdata_o, csr_hit_o
  );

  modport slave (
    input  csr_access_i, csr_addr_i, csr_wdata_i, csr_op_i,
    output csr_rdata_o, csr_hit_o
  );
endinterface

// File: rtl/riscv_perf_counters.sv
// Parametrised performance counters with per-counter event select, wrap/saturate and sticky overflow.
// Latency: event strobe -> readable count 2 cycles; CSR read combinational, CSR update at the next edge.
// Backpressure: none; CSR accesses always complete in one cycle, events are never stalled.
//
// Ports:
//   clk         core clock
//   rst         synchronous active-high reset
//   csr         CSR access channel (slave modport), window 0x780-0x7AF
//   events_i    single-cycle event strobes, N_EVENTS wide
//   perf_irq_o  level overflow interrupt
// Optional feature macro: PERF_OVF_IRQ_EN adds the OVF_IE register (0x7A3) and a registered interrupt.
module riscv_perf_counters #(
  parameter int N_CNT        = 4,
  parameter int CNT_WIDTH    = 32,
  parameter int N_EVENTS     = 16,
  parameter int EVT_SEL_BITS = $clog2(N_EVENTS)
) (
  input  logic                clk,
  input  logic                rst,
  riscv_perf_counters_if.slave csr,
  input  logic [N_EVENTS-1:0] events_i,
  output logic                perf_irq_o
);

  localparam logic [1:0] CSR_OP_NONE  = 2'b00;
  localparam logic [1:0] CSR_OP_WRITE = 2'b01;
  localparam logic [1:0] CSR_OP_SET   = 2'b10;
  localparam logic [1:0] CSR_OP_CLEAR = 2'b11;

  function automatic logic [31:0] csr_apply(input logic [1:0] op,
                                            input logic [31:0] old,
                                            input logic [31:0] wd);
    case (op)
      CSR_OP_WRITE: return wd;
      CSR_OP_SET:   return old | wd;
      CSR_OP_CLEAR: return old & ~wd;
      default:      return old;
    endcase
  endfunction

  // State
  logic [CNT_WIDTH-1:0]    cnt_q   [N_CNT];
  logic [EVT_SEL_BITS-1:0] evsel_q [N_CNT];
  logic [N_CNT-1:0]        en_q;
  logic [N_CNT-1:0]        ovf_q;
  logic [N_CNT-1:0]        inc_q;
  logic [1:0]              mode_q;

  // Decode
  logic [N_CNT-1:0] lo_sel, hi_sel, evs_sel;
  logic             en_sel, mode_sel, ovf_sel, ie_sel;
  logic             wr;
  logic [31:0]      rdata;
  logic             hit;

  // Counters viewed through a 64-bit window so LO/HI halves are uniform for any width
  logic [63:0]          cnt_ext [N_CNT];
  logic [CNT_WIDTH-1:0] cnt_d   [N_CNT];
  logic [N_CNT-1:0]     ovf_set;
  logic [N_CNT-1:0]     evt_hit;

`ifdef PERF_OVF_IRQ_EN
  logic [N_CNT-1:0] ovf_ie_q;
  logic             irq_q;
`endif

  assign wr = csr.csr_access_i && (csr.csr_op_i != CSR_OP_NONE);

  always_comb begin
    lo_sel   = '0;
    hi_sel   = '0;
    evs_sel  = '0;
    en_sel   = csr.csr_access_i && (csr.csr_addr_i == 12'h7A0);
    mode_sel = csr.csr_access_i && (csr.csr_addr_i == 12'h7A1);
    ovf_sel  = csr.csr_access_i && (csr.csr_addr_i == 12'h7A2);
`ifdef PERF_OVF_IRQ_EN
    ie_sel   = csr.csr_access_i && (csr.csr_addr_i == 12'h7A3);
`else
    ie_sel   = 1'b0;
`endif
    for (int i = 0; i < N_CNT; i++) begin
      lo_sel[i]  = csr.csr_access_i && (csr.csr_addr_i == 12'h780 + 12'(i));
      hi_sel[i]  = csr.csr_access_i && (csr.csr_addr_i == 12'h790 + 12'(i));
      evs_sel[i] = csr.csr_access_i && (csr.csr_addr_i == 12'h7A8 + 12'(i));
    end
  end

  always_comb begin
    for (int i = 0; i < N_CNT; i++) begin
      cnt_ext[i] = 64'(cnt_q[i]);
    end
  end

  // Read mux: at most one select is active, so OR-combining is a clean mux.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < N_CNT; i++) begin
      if (lo_sel[i])  rdata = rdata | cnt_ext[i][31:0];
      if (hi_sel[i])  rdata = rdata | cnt_ext[i][63:32];
      if (evs_sel[i]) rdata = rdata | 32'(evsel_q[i]);
    end
    if (en_sel)   rdata = rdata | 32'(en_q);
    if (mode_sel) rdata = rdata | 32'(mode_q);
    if (ovf_sel)  rdata = rdata | 32'(ovf_q);
`ifdef PERF_OVF_IRQ_EN
    if (ie_sel)   rdata = rdata | 32'(ovf_ie_q);
`endif
  end

  assign hit = (|lo_sel) | (|hi_sel) | (|evs_sel) | en_sel | mode_sel | ovf_sel | ie_sel;

  assign csr.csr_rdata_o = rdata;
  assign csr.csr_hit_o   = hit;

  // Event select; selector values with no matching input leave the strobe at 0.
  always_comb begin
    evt_hit = '0;
    for (int i = 0; i < N_CNT; i++) begin
      for (int e = 0; e < N_EVENTS; e++) begin
        if (evsel_q[i] == EVT_SEL_BITS'(e)) evt_hit[i] = events_i[e];
      end
    end
  end

  // Counter next-state: a CSR write to either half pre-empts the pending increment.
  // HI writes are dropped entirely when the counter has no upper half.
  always_comb begin
    for (int i = 0; i < N_CNT; i++) begin
      cnt_d[i]   = cnt_q[i];
      ovf_set[i] = 1'b0;
      if (wr && lo_sel[i]) begin
        cnt_d[i] = CNT_WIDTH'({cnt_ext[i][63:32],
                               csr_apply(csr.csr_op_i, cnt_ext[i][31:0], csr.csr_wdata_i)});
      end else if (wr && hi_sel[i] && (CNT_WIDTH > 32)) begin
        cnt_d[i] = CNT_WIDTH'({csr_apply(csr.csr_op_i, cnt_ext[i][63:32], csr.csr_wdata_i),
                               cnt_ext[i][31:0]});
      end else if (inc_q[i]) begin
        if (&cnt_q[i]) begin
          ovf_set[i] = 1'b1;
          cnt_d[i]   = mode_q[1] ? cnt_q[i] : '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CNT; i++) begin
        cnt_q[i]   <= '0;
        evsel_q[i] <= '0;
      end
      en_q   <= '0;
      ovf_q  <= '0;
      inc_q  <= '0;
      mode_q <= 2'b11;
    end else begin
      for (int i = 0; i < N_CNT; i++) begin
        cnt_q[i] <= cnt_d[i];
        if (wr && evs_sel[i]) begin
          evsel_q[i] <= EVT_SEL_BITS'(csr_apply(csr.csr_op_i, 32'(evsel_q[i]), csr.csr_wdata_i));
        end
      end
      inc_q <= en_q & {N_CNT{mode_q[0]}} & evt_hit;
      if (wr && en_sel) begin
        en_q <= N_CNT'(csr_apply(csr.csr_op_i, 32'(en_q), csr.csr_wdata_i));
      end
      if (wr && mode_sel) begin
        mode_q <= 2'(csr_apply(csr.csr_op_i, 32'(mode_q), csr.csr_wdata_i));
      end
      // A fresh overflow beats a software clear in the same cycle.
      if (wr && ovf_sel) begin
        ovf_q <= N_CNT'(csr_apply(csr.csr_op_i, 32'(ovf_q), csr.csr_wdata_i)) | ovf_set;
      end else begin
        ovf_q <= ovf_q | ovf_set;
      end
    end
  end

`ifdef PERF_OVF_IRQ_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_ie_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      if (wr && ie_sel) begin
        ovf_ie_q <= N_CNT'(csr_apply(csr.csr_op_i, 32'(ovf_ie_q), csr.csr_wdata_i));
      end
      irq_q <= |(ovf_q & ovf_ie_q);
    end
  end
  assign perf_irq_o = irq_q;
`else
  assign perf_irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_perf_counters.sv
// Directed bench for riscv_perf_counters: a 32-bit instance for the main behaviour and a
// 40-bit instance for the LO->HI carry and HI register width.
module tb_riscv_perf_counters;
  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] events;
  logic        irq, irq40;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  riscv_perf_counters_if bus ();
  riscv_perf_counters_if bus40 ();

  riscv_perf_counters #(.N_CNT(4), .CNT_WIDTH(32), .N_EVENTS(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .csr        (bus.slave),
    .events_i   (events),
    .perf_irq_o (irq)
  );

  riscv_perf_counters #(.N_CNT(4), .CNT_WIDTH(40), .N_EVENTS(16)) dut40 (
    .clk        (clk),
    .rst        (rst),
    .csr        (bus40.slave),
    .events_i   (events),
    .perf_irq_o (irq40)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input bit w40, input logic acc, input logic [11:0] a,
                     input logic [1:0] op, input logic [31:0] d);
    if (w40) begin
      bus40.csr_access_i = acc; bus40.csr_addr_i = a; bus40.csr_op_i = op; bus40.csr_wdata_i = d;
    end else begin
      bus.csr_access_i = acc; bus.csr_addr_i = a; bus.csr_op_i = op; bus.csr_wdata_i = d;
    end
  endtask

  // All tasks start and end at a falling edge with the bus idle.
  task automatic csr_op(input bit w40, input logic [11:0] a, input logic [1:0] op,
                        input logic [31:0] d);
    drv(w40, 1'b1, a, op, d);
    @(negedge clk);
    drv(w40, 1'b0, 12'h0, OP_NONE, 32'h0);
  endtask

  task automatic rd(input bit w40, input logic [11:0] a, input logic [31:0] exp,
                    input logic exp_hit, input string tag);
    logic [31:0] d;
    logic        h;
    drv(w40, 1'b1, a, OP_NONE, 32'h0);
    #1;
    d = w40 ? bus40.csr_rdata_o : bus.csr_rdata_o;
    h = w40 ? bus40.csr_hit_o : bus.csr_hit_o;
    chk(tag, d, exp);
    chk({tag, "_hit"}, {31'b0, h}, {31'b0, exp_hit});
    @(negedge clk);
    drv(w40, 1'b0, 12'h0, OP_NONE, 32'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int e, input int n);
    events[e] = 1'b1;
    repeat (n) @(negedge clk);
    events = '0;
  endtask

  initial begin
    rst = 1'b1;
    events = '0;
    drv(1'b0, 1'b0, 12'h0, OP_NONE, 32'h0);
    drv(1'b1, 1'b0, 12'h0, OP_NONE, 32'h0);
    idle(3);
    rst = 1'b0;

    // Reset state
    chk("rst_irq", {31'b0, irq}, 32'h0);
    chk("rst_idle_hit", {31'b0, bus.csr_hit_o}, 32'h0);
    chk("rst_idle_rdata", bus.csr_rdata_o, 32'h0);
    rd(0, 12'h7A1, 32'h3, 1'b1, "rst_mode");
    rd(0, 12'h780, 32'h0, 1'b1, "rst_cnt0");
`ifdef PERF_OVF_IRQ_EN
    rd(0, 12'h7A3, 32'h0, 1'b1, "rst_ovf_ie");
`else
    rd(0, 12'h7A3, 32'h0, 1'b0, "rst_ovf_ie");
`endif

    // Counter 1 on event 5, ten strobes
    csr_op(0, 12'h7A9, OP_WRITE, 32'd5);
    csr_op(0, 12'h7A0, OP_WRITE, 32'h2);
    pulse(5, 10);
    idle(2);
    rd(0, 12'h781, 32'd10, 1'b1, "cnt1_ten");
    rd(0, 12'h780, 32'd0, 1'b1, "cnt0_idle");

    // Two-cycle latency: not visible the next cycle, visible the one after
    events[5] = 1'b1;
    @(negedge clk);
    events = '0;
    rd(0, 12'h781, 32'd10, 1'b1, "lat_t1");
    rd(0, 12'h781, 32'd11, 1'b1, "lat_t2");

    // Wrap mode overflow
    csr_op(0, 12'h7A1, OP_WRITE, 32'h1);
    csr_op(0, 12'h7A0, OP_WRITE, 32'h1);
    csr_op(0, 12'h780, OP_WRITE, 32'hFFFF_FFFF);
    pulse(0, 1);
    idle(2);
    rd(0, 12'h780, 32'h0, 1'b1, "wrap_cnt");
    rd(0, 12'h7A2, 32'h1, 1'b1, "wrap_ovf");
    csr_op(0, 12'h7A2, OP_CLEAR, 32'h1);
    rd(0, 12'h7A2, 32'h0, 1'b1, "ovf_clear");

    // Saturate mode overflow
    csr_op(0, 12'h7A1, OP_WRITE, 32'h3);
    csr_op(0, 12'h780, OP_WRITE, 32'hFFFF_FFFF);
    pulse(0, 1);
    idle(2);
    rd(0, 12'h780, 32'hFFFF_FFFF, 1'b1, "sat_cnt");
    rd(0, 12'h7A2, 32'h1, 1'b1, "sat_ovf");

    // Write wins over a simultaneous increment
    csr_op(0, 12'h780, OP_WRITE, 32'h0);
    events[0] = 1'b1;
    idle(5);
    csr_op(0, 12'h780, OP_WRITE, 32'h100);
    rd(0, 12'h780, 32'h100, 1'b1, "wr_win_0");
    rd(0, 12'h780, 32'h101, 1'b1, "wr_win_1");
    events = '0;
    idle(2);

    // Overflow set wins over a simultaneous clear
    csr_op(0, 12'h7A2, OP_CLEAR, 32'hF);
    csr_op(0, 12'h780, OP_WRITE, 32'hFFFF_FFFF);
    events[0] = 1'b1;
    idle(3);
    csr_op(0, 12'h7A2, OP_CLEAR, 32'h1);
    rd(0, 12'h7A2, 32'h1, 1'b1, "set_wins");
    events = '0;
    idle(2);
    csr_op(0, 12'h7A2, OP_CLEAR, 32'hF);
    rd(0, 12'h7A2, 32'h0, 1'b1, "ovf_cleared");

    // SET/CLEAR ops, field widths, unmapped addresses
    csr_op(0, 12'h7A0, OP_SET, 32'h4);
    rd(0, 12'h7A0, 32'h5, 1'b1, "en_set");
    csr_op(0, 12'h7A0, OP_CLEAR, 32'h1);
    rd(0, 12'h7A0, 32'h4, 1'b1, "en_clear");
    csr_op(0, 12'h7A8, OP_WRITE, 32'hFFFF_FFFF);
    rd(0, 12'h7A8, 32'hF, 1'b1, "evsel_width");
    rd(0, 12'h7A9, 32'h5, 1'b1, "evsel1");
    rd(0, 12'h784, 32'h0, 1'b0, "unmap_cnt4");
    rd(0, 12'h7AC, 32'h0, 1'b0, "unmap_evsel4");
    rd(0, 12'h7A4, 32'h0, 1'b0, "unmap_7a4");
    csr_op(0, 12'h790, OP_WRITE, 32'h1234);
    rd(0, 12'h790, 32'h0, 1'b1, "hi32_ro");
    drv(0, 1'b0, 12'h7A1, OP_NONE, 32'h0);
    #1;
    chk("noacc_rdata", bus.csr_rdata_o, 32'h0);
    chk("noacc_hit", {31'b0, bus.csr_hit_o}, 32'h0);
    @(negedge clk);

    // Overflow interrupt
    csr_op(0, 12'h7A8, OP_WRITE, 32'h0);
    csr_op(0, 12'h7A0, OP_WRITE, 32'h1);
    csr_op(0, 12'h7A1, OP_WRITE, 32'h1);
`ifdef PERF_OVF_IRQ_EN
    csr_op(0, 12'h7A3, OP_WRITE, 32'h1);
    rd(0, 12'h7A3, 32'h1, 1'b1, "ovf_ie");
`endif
    csr_op(0, 12'h780, OP_WRITE, 32'hFFFF_FFFF);
    pulse(0, 1);
    idle(3);
`ifdef PERF_OVF_IRQ_EN
    chk("irq_set", {31'b0, irq}, 32'h1);
    csr_op(0, 12'h7A2, OP_CLEAR, 32'h1);
    chk("irq_hold", {31'b0, irq}, 32'h1);
    @(negedge clk);
    chk("irq_clr", {31'b0, irq}, 32'h0);
`else
    chk("irq_tied", {31'b0, irq}, 32'h0);
    rd(0, 12'h7A2, 32'h1, 1'b1, "ovf_noirq");
`endif

    // Reset during counting, including a pending increment
    csr_op(0, 12'h780, OP_WRITE, 32'h5);
    events[0] = 1'b1;
    idle(2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rd(0, 12'h780, 32'h0, 1'b1, "rst_run_cnt_a");
    rd(0, 12'h780, 32'h0, 1'b1, "rst_run_cnt_b");
    rd(0, 12'h7A1, 32'h3, 1'b1, "rst_run_mode");
    rd(0, 12'h7A0, 32'h0, 1'b1, "rst_run_en");
    rd(0, 12'h7A2, 32'h0, 1'b1, "rst_run_ovf");
    events = '0;

    // 40-bit counter: carry from LO into HI, HI width
    csr_op(1, 12'h7A0, OP_WRITE, 32'h1);
    csr_op(1, 12'h790, OP_WRITE, 32'h0);
    csr_op(1, 12'h780, OP_WRITE, 32'hFFFF_FFFF);
    pulse(0, 1);
    idle(2);
    rd(1, 12'h790, 32'h1, 1'b1, "w40_hi");
    rd(1, 12'h780, 32'h0, 1'b1, "w40_lo");
    rd(1, 12'h7A2, 32'h0, 1'b1, "w40_ovf");
    csr_op(1, 12'h790, OP_WRITE, 32'hFFFF_FFFF);
    rd(1, 12'h790, 32'hFF, 1'b1, "w40_hi_width");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
